spi_rx: RTL and testbench

- 8-bit SPI receiver (peripheral/slave side) for the same 4-wire format the on-chip SPI output driver produces:
  - cs_ active-low;
  - sck idles high;
  - data changes on sck falling edge and is sampled on sck rising edge;
  - MSB first;
  - an optional D/C line is captured per byte.
- Oversamples the external lines with clk_125mhz and queues received bytes in a small first-word-fall-through FIFO.
- The CPU side reads the FIFO through a memory-mapped read port in the top level.
- Intended for loopback testing of the output driver and for external SPI sources such as sensors or a second board.

---
 rtl/spi_rx_if.sv | 29 ++
 rtl/spi_rx.sv | 219 +++++++++++++++++++++
 tb/tb_spi_rx.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rx_if.sv
// Bundle of the SPI receiver's external serial lines, CPU read port and status
// outputs; the design takes the slave view, the driving side takes the master view.
interface spi_rx_if #(
  parameter int DEPTH_LOG2 = 2
) ();

  logic                  spi_sck;
  logic                  spi_sdi;
  logic                  spi_cs_;
  logic                  spi_dc;
  logic                  pop;
  logic                  clr_err;
  logic [8:0]            rx_data;
  logic                  rx_valid;
  logic [DEPTH_LOG2:0]   rx_count;
  logic                  overrun;
  logic                  frame_err;

  modport master (
    output spi_sck, spi_sdi, spi_cs_, spi_dc, pop, clr_err,
    input  rx_data, rx_valid, rx_count, overrun, frame_err
  );

  modport slave (
    input  spi_sck, spi_sdi, spi_cs_, spi_dc, pop, clr_err,
    output rx_data, rx_valid, rx_count, overrun, frame_err
  );

endinterface

// File: rtl/spi_rx.sv
// SPI peripheral receiver: oversampled 4-wire input (sck idles high, sample on
// rising edge, MSB first) feeding a first-word-fall-through FIFO of {dc, byte}.
module spi_rx #(
  parameter int DEPTH_LOG2  = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic     clk_125mhz,
  input logic     reset,
  spi_rx_if.slave bus
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = (DEPTH_LOG2)'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  logic [SYNC_N-1:0]     sck_sync_r;
  logic [SYNC_N-1:0]     sdi_sync_r;
  logic [SYNC_N-1:0]     cs_sync_r;
  logic [SYNC_N-1:0]     dc_sync_r;
  logic                  sck_d_r;
  logic                  sck_s;
  logic                  sdi_s;
  logic                  cs_s;
  logic                  dc_s;
  logic                  rise_s;

  logic [0:0]            state_r;
  logic [2:0]            bit_cnt_r;
  logic [7:0]            shift_r;
  logic                  byte_done_s;
  logic                  frame_evt_s;
  logic [8:0]            new_entry_s;

  logic [8:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt_s;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic [8:0]            head_r;
  logic [8:0]            head_nxt_s;
  logic                  valid_r;
  logic                  pop_ok_s;
  logic                  push_ok_s;
  logic                  drop_s;
  logic                  overrun_r;
  logic                  frame_err_r;

  // Metastability chains; sck/cs_ reset to their idle-high level
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      sck_sync_r <= {SYNC_N{1'b1}};
      cs_sync_r  <= {SYNC_N{1'b1}};
      sdi_sync_r <= {SYNC_N{1'b0}};
      dc_sync_r  <= {SYNC_N{1'b0}};
      sck_d_r    <= 1'b1;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC_N-2:0], bus.spi_sck};
      cs_sync_r  <= {cs_sync_r[SYNC_N-2:0],  bus.spi_cs_};
      sdi_sync_r <= {sdi_sync_r[SYNC_N-2:0], bus.spi_sdi};
      dc_sync_r  <= {dc_sync_r[SYNC_N-2:0],  bus.spi_dc};
      sck_d_r    <= sck_sync_r[SYNC_N-1];
    end
  end

  assign sck_s  = sck_sync_r[SYNC_N-1];
  assign sdi_s  = sdi_sync_r[SYNC_N-1];
  assign cs_s   = cs_sync_r[SYNC_N-1];
  assign dc_s   = dc_sync_r[SYNC_N-1];
  assign rise_s = sck_s & ~sck_d_r;

  // Byte framing state machine; chip-select release takes priority over a rise
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!cs_s) begin
            state_r   <= ST_RECV;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
          end
        end
        ST_RECV: begin
          if (cs_s) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
          end else if (rise_s) begin
            // the 3-bit counter wraps from 7 to 0 after the byte is queued
            shift_r   <= {shift_r[6:0], sdi_s};
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= 3'd0;
          shift_r   <= 8'd0;
        end
      endcase
    end
  end

  // Completed-byte and truncated-frame events seen by the FIFO and error flags
  always_comb begin
    byte_done_s = 1'b0;
    frame_evt_s = 1'b0;
    new_entry_s = {dc_s, shift_r[6:0], sdi_s};
    if (state_r == ST_RECV) begin
      byte_done_s = !cs_s && rise_s && (bit_cnt_r == 3'd7);
      frame_evt_s = cs_s && (bit_cnt_r != 3'd0);
    end else begin
      byte_done_s = 1'b0;
      frame_evt_s = 1'b0;
    end
  end

  // FIFO next-state: a pop frees the slot that a simultaneous push may use
  always_comb begin
    pop_ok_s     = bus.pop && (count_r != CNT_ZERO);
    push_ok_s    = 1'b0;
    drop_s       = 1'b0;
    count_nxt_s  = count_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = 9'd0;
    if (byte_done_s) begin
      push_ok_s = (count_r != CNT_FULL) || pop_ok_s;
      drop_s    = !push_ok_s;
    end else begin
      push_ok_s = 1'b0;
      drop_s    = 1'b0;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    if (pop_ok_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // the new byte becomes head only when it lands in the slot the read pointer reaches
    if (count_nxt_s == CNT_ZERO) begin
      head_nxt_s = 9'd0;
    end else if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = new_entry_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 9'd0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= new_entry_s;
    end
  end

  // FIFO pointers, occupancy and registered head view
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      valid_r  <= 1'b0;
      head_r   <= 9'd0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != CNT_ZERO);
      head_r   <= head_nxt_s;
    end
  end

  // Sticky error flags; a new event outranks a same-cycle clear
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (bus.clr_err) begin
        overrun_r <= 1'b0;
      end
      if (frame_evt_s) begin
        frame_err_r <= 1'b1;
      end else if (bus.clr_err) begin
        frame_err_r <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = head_r;
  assign bus.rx_valid  = valid_r;
  assign bus.rx_count  = count_r;
  assign bus.overrun   = overrun_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: a transaction-level queue model (bytes land a fixed latency
// after the 8th sck rise) checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_spi_rx;

  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  spi_rx_if #(.DEPTH_LOG2(DL)) bus ();

  spi_rx #(.DEPTH_LOG2(DL), .SYNC_STAGES(SYNC)) dut (
    .clk_125mhz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #4 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit started = 1'b0;
  bit pop_rand = 1'b0;
  int pop_at = -10;
  int clr_at = -10;
  int pend_bits = 0;

  // scheduled model events: kind 0 = byte arrives, kind 1 = truncated frame
  int       ev_at   [1024];
  bit       ev_kind [1024];
  bit [8:0] ev_val  [1024];
  int       ev_wr = 0;
  int       ev_rd = 0;

  bit [8:0] m_q[$];
  bit       m_ovr = 1'b0;
  bit       m_fe = 1'b0;
  bit       m_pop;
  int       m_sz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, events applied at their scheduled edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      ev_rd = ev_wr;
    end else begin
      cyc++;
      m_sz  = m_q.size();
      m_pop = bus.pop && (m_sz != 0);
      if (bus.clr_err) begin
        m_ovr = 1'b0;
        m_fe  = 1'b0;
      end
      if (m_pop) void'(m_q.pop_front());
      while (ev_rd != ev_wr && ev_at[ev_rd % 1024] <= cyc) begin
        if (ev_kind[ev_rd % 1024] == 1'b0) begin
          if (m_sz < DEPTH || m_pop) m_q.push_back(ev_val[ev_rd % 1024]);
          else m_ovr = 1'b1;
        end else begin
          m_fe = 1'b1;
        end
        ev_rd++;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (bus.rx_valid !== (m_q.size() != 0) ||
          bus.rx_count !== (DL + 1)'(m_q.size()) ||
          (m_q.size() != 0 && bus.rx_data !== m_q[0]) ||
          bus.overrun !== m_ovr || bus.frame_err !== m_fe) begin
        errors++;
        $display("FAIL cycle %0d: dut v=%b c=%0d d=%h o=%b f=%b model v=%b c=%0d d=%h o=%b f=%b",
                 cyc, bus.rx_valid, bus.rx_count, bus.rx_data, bus.overrun, bus.frame_err,
                 (m_q.size() != 0), m_q.size(), (m_q.size() != 0) ? m_q[0] : 9'd0, m_ovr, m_fe);
      end
    end
  end

  // pop / clr_err pulse generator
  always @(negedge clk) begin
    bus.pop     = (cyc + 1 == pop_at) || (pop_rand && $urandom_range(0, 99) == 0);
    bus.clr_err = (cyc + 1 == clr_at);
  end

  task automatic sched(input bit kind, input bit [8:0] val, input int at);
    ev_at[ev_wr % 1024]   = at;
    ev_kind[ev_wr % 1024] = kind;
    ev_val[ev_wr % 1024]  = val;
    ev_wr++;
  endtask

  // send the top n bits of v, half period h clk cycles
  task automatic spi_byte(input logic [7:0] v, input int n, input logic d, input int h,
                          input bit lat_chk, input bit pop_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.spi_sck = 1'b0;
      bus.spi_sdi = v[7-i];
      bus.spi_dc  = d;
      repeat (h - 1) @(negedge clk);
      @(negedge clk);
      bus.spi_sck = 1'b1;
      if (i == 7) begin
        sched(1'b0, {d, v}, cyc + LAT);
        if (pop_last) pop_at = cyc + LAT;
      end
      for (int j = 1; j < h; j++) begin
        @(negedge clk);
        if (lat_chk && i == 7 && j == LAT - 1) chk("lat_before", bus.rx_valid, 0);
        if (lat_chk && i == 7 && j == LAT) chk("lat_after", bus.rx_valid, 1);
      end
    end
    pend_bits = (n < 8) ? n : 0;
  endtask

  task automatic cs_lo();
    @(negedge clk);
    bus.spi_cs_ = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_hi();
    @(negedge clk);
    bus.spi_cs_ = 1'b1;
    if (pend_bits != 0) sched(1'b1, 9'd0, cyc + LAT);
    pend_bits = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) begin
      pop_at = cyc + 2;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic clear_errs();
    clr_at = cyc + 2;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int hp;
    bus.spi_sck = 1'b1;
    bus.spi_cs_ = 1'b1;
    bus.spi_sdi = 1'b0;
    bus.spi_dc  = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_count", bus.rx_count, 0);
    chk("rst_data", bus.rx_data, 0);
    chk("rst_flags", {bus.overrun, bus.frame_err}, 0);
    #2 reset = 1'b0;
    started = 1'b1;

    // single byte at 1.25 MHz
    cs_lo();
    spi_byte(8'hA5, 8, 1'b1, 50, 1'b0, 1'b0);
    cs_hi();
    chk("t1_data", bus.rx_data, 9'h1A5);
    chk("t1_count", bus.rx_count, 1);
    chk("t1_flags", {bus.overrun, bus.frame_err}, 0);
    pop_at = cyc + 2;
    repeat (3) @(negedge clk);
    chk("t1_pop_valid", bus.rx_valid, 0);
    chk("t1_pop_count", bus.rx_count, 0);

    // three bytes in one frame, with latency check on the first
    cs_lo();
    spi_byte(8'h01, 8, 1'b0, 5, 1'b1, 1'b0);
    spi_byte(8'h80, 8, 1'b0, 5, 1'b0, 1'b0);
    spi_byte(8'hFF, 8, 1'b0, 5, 1'b0, 1'b0);
    cs_hi();
    chk("t2_count", bus.rx_count, 3);
    chk("t2_head", bus.rx_data, 9'h001);
    drain();

    // overflow: five bytes into four slots
    cs_lo();
    for (int i = 0; i < 5; i++) spi_byte(8'(8'h10 + i), 8, 1'(i), 5, 1'b0, 1'b0);
    cs_hi();
    chk("t3_count", bus.rx_count, 4);
    chk("t3_overrun", bus.overrun, 1);
    chk("t3_head", bus.rx_data, 9'h010);
    clear_errs();
    chk("t3_clr", bus.overrun, 0);

    // full FIFO, pop coincides with the byte write
    cs_lo();
    spi_byte(8'h66, 8, 1'b1, 5, 1'b0, 1'b1);
    cs_hi();
    chk("t4_count", bus.rx_count, 4);
    chk("t4_overrun", bus.overrun, 0);
    chk("t4_head", bus.rx_data, 9'h111);
    drain();

    // truncated frame then a good byte
    cs_lo();
    spi_byte(8'hE0, 3, 1'b0, 5, 1'b0, 1'b0);
    cs_hi();
    chk("t5_frame_err", bus.frame_err, 1);
    chk("t5_count", bus.rx_count, 0);
    cs_lo();
    spi_byte(8'h3C, 8, 1'b0, 5, 1'b0, 1'b0);
    cs_hi();
    chk("t5_data", bus.rx_data, 9'h03C);
    clear_errs();
    drain();

    // randomized frames with random pops, partial bytes and clears
    pop_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      nb = $urandom_range(1, 4);
      hp = $urandom_range(4, 7);
      cs_lo();
      for (int b = 0; b < nb; b++) spi_byte(8'($urandom), 8, 1'($urandom), hp, 1'b0, 1'b0);
      if ($urandom_range(0, 4) == 0) spi_byte(8'($urandom), $urandom_range(1, 7), 1'b0, hp, 1'b0, 1'b0);
      cs_hi();
      if ($urandom_range(0, 3) == 0) clear_errs();
    end
    pop_rand = 1'b0;
    repeat (4) @(negedge clk);
    drain();
    clear_errs();

    // reset mid-byte with two entries queued
    cs_lo();
    spi_byte(8'h11, 8, 1'b0, 5, 1'b0, 1'b0);
    spi_byte(8'h22, 8, 1'b1, 5, 1'b0, 1'b0);
    spi_byte(8'hFF, 2, 1'b0, 5, 1'b0, 1'b0);
    chk("t6_pre_count", bus.rx_count, 2);
    @(negedge clk);
    #2 reset = 1'b1;
    bus.spi_cs_ = 1'b1;
    bus.spi_sck = 1'b1;
    pend_bits = 0;
    #1;
    chk("t6_rst_valid", bus.rx_valid, 0);
    chk("t6_rst_count", bus.rx_count, 0);
    chk("t6_rst_data", bus.rx_data, 0);
    chk("t6_rst_flags", {bus.overrun, bus.frame_err}, 0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    cs_lo();
    spi_byte(8'h5A, 8, 1'b0, 5, 1'b0, 1'b0);
    cs_hi();
    chk("t6_data", bus.rx_data, 9'h05A);
    chk("t6_count", bus.rx_count, 1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
